// File: rtl/dram_pkg.sv
// Shared types and defaults for the DRAM backing store.
// FSM state encoding, default widths and latency counter width.
package dram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LINE_W_DEF = 128;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/dram_line_array.sv
// DEPTH x LINE_W line storage for the DRAM backing store.
// Synchronous write port and registered read port with clear.
module dram_line_array #(
  parameter int DEPTH  = 256,
  parameter int LINE_W = 128,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_backing_store.sv
// Fixed-latency line memory behind the L1 controller (cs/we handshake).
// Optional out-of-range detection: define DRAM_RANGE_CHECK_EN.
module dram_backing_store
  import dram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_cs,
  input  logic              dram_we,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [LINE_W-1:0] dram_wdata,
  output logic [LINE_W-1:0] dram_rdata,
  output logic              dram_ack,
  output logic              dram_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic               ack_q, ack_d;
  logic               oor;
  logic               fire;
  logic               mem_we;
  logic               mem_re;
  logic               mem_rclr;

`ifdef DRAM_RANGE_CHECK_EN
  logic err_q;

  assign oor = {1'b0, addr_q} >= (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fire & oor;
    end
  end

  assign dram_err = err_q;
`else
  // Upper address bits alias modulo DEPTH.
  assign oor      = 1'b0;
  assign dram_err = 1'b0;

  if (ADDR_W > IDX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^addr_q[ADDR_W-1:IDX_W];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    fire     = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_rclr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dram_cs) begin
          we_d    = dram_we;
          addr_d  = dram_addr;
          wdata_d = dram_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          fire     = 1'b1;
          mem_we   = we_q & ~oor;
          mem_re   = ~we_q & ~oor;
          mem_rclr = ~we_q & oor;
          ack_d    = 1'b1;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // A cs still held after ack must not start a second transaction.
        if (!dram_cs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  dram_line_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .rclr_i  (mem_rclr),
    .idx_i   (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (dram_rdata)
  );

  assign dram_ack = ack_q;

endmodule

// File: tb/tb_dram_backing_store.sv
// Bench for dram_backing_store: LATENCY=10 and LATENCY=1 instances
// checked each cycle against a transaction-level model.
module tb_dram_backing_store;

`ifdef DRAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  localparam logic [127:0] D5  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D7  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D20 = 128'h20202020_A5A5A5A5_5A5A5A5A_00000020;
  localparam logic [127:0] DA  = 128'hAAAA0000_AAAA0000_AAAA0000_AAAA00FF;
  localparam logic [127:0] DB  = 128'hBBBB1111_BBBB1111_BBBB1111_BBBB11FF;
  localparam logic [127:0] E1  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] E2  = 128'hFEEDFACE_00000000_FFFFFFFF_12345678;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs    [2];
  logic         we    [2];
  logic [9:0]   addr  [2];
  logic [127:0] wd    [2];
  logic [127:0] rd    [2];
  logic         ack   [2];
  logic         err   [2];

  int           edges  = 0;
  int           checks = 0;
  int           passes = 0;
  bit           run_cmp = 1'b0;
  int           ack_at [2];
  bit           pw     [2];
  logic [9:0]   pa     [2];
  logic [127:0] pd     [2];
  logic [127:0] exp_rd [2];
  logic [127:0] mm     [2][256];
  logic         e;

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  dram_backing_store #(
    .ADDR_W (10), .LINE_W (128), .DEPTH (256), .LATENCY (10)
  ) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .dram_cs    (cs[0]),
    .dram_we    (we[0]),
    .dram_addr  (addr[0]),
    .dram_wdata (wd[0]),
    .dram_rdata (rd[0]),
    .dram_ack   (ack[0]),
    .dram_err   (err[0])
  );

  dram_backing_store #(
    .ADDR_W (10), .LINE_W (128), .DEPTH (256), .LATENCY (1)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .dram_cs    (cs[1]),
    .dram_we    (we[1]),
    .dram_addr  (addr[1]),
    .dram_wdata (wd[1]),
    .dram_rdata (rd[1]),
    .dram_ack   (ack[1]),
    .dram_err   (err[1])
  );

  function automatic int lat(int d);
    return (d == 0) ? 10 : 1;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model: ack lands exactly LATENCY+1 edges after cs is raised from idle.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int d = 0; d < 2; d++) begin
        bit hit;
        bit bad;
        hit = (edges == ack_at[d]);
        bad = RC && (pa[d] >= 10'd256);
        if (hit) begin
          if (pw[d]) begin
            if (!bad) mm[d][pa[d][7:0]] = pd[d];
          end else begin
            exp_rd[d] = bad ? 128'h0 : mm[d][pa[d][7:0]];
          end
        end
        chk($sformatf("cyc_ack%0d@%0d", d, edges), 128'(ack[d]), 128'(hit));
        chk($sformatf("cyc_err%0d@%0d", d, edges), 128'(err[d]),
            128'(hit && bad));
        chk($sformatf("cyc_rd%0d@%0d", d, edges), rd[d], exp_rd[d]);
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ack_at[d] = -1;
      exp_rd[d] = '0;
    end
  endtask

  // Called at posedge+2 with the target instance idle.
  task automatic req(input int d, input bit w, input logic [9:0] a,
                     input logic [127:0] data, input int hold,
                     input bit early, input int abort_at,
                     output logic e_o);
    e_o = 1'b0;
    cs[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data;
    pw[d] = w; pa[d] = a; pd[d] = data;
    ack_at[d] = edges + 1 + lat(d);
    @(posedge clk); #2;
    we[d] = ~w; addr[d] = ~a; wd[d] = ~data;
    if (early) cs[d] = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) begin
        @(posedge clk); #2;
      end
      rst = 1'b0;
      model_reset();
      cs[d] = 1'b0;
      repeat (2) begin
        @(posedge clk); #2;
      end
      rst = 1'b1;
      repeat (lat(d) + 4) begin
        @(posedge clk); #2;
      end
    end else begin
      repeat (lat(d) - 1) begin
        @(posedge clk); #2;
      end
      chk("pre_ack", 128'(ack[d]), 128'h0);
      @(posedge clk); #2;
      chk("ack_pulse", 128'(ack[d]), 128'h1);
      e_o = err[d];
      repeat (hold) begin
        @(posedge clk); #2;
      end
      cs[d] = 1'b0;
      repeat (2) begin
        @(posedge clk); #2;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wd[d] = '0;
      pw[d] = 1'b0; pa[d] = '0; pd[d] = '0;
    end
    model_reset();
    @(posedge clk); #2;
    run_cmp = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
    end
    chk("rst_rdata", rd[0], 128'h0);
    chk("rst_ack", 128'(ack[0]), 128'h0);
    rst = 1'b1;
    repeat (20) begin
      @(posedge clk); #2;
    end

    req(0, 1'b1, 10'h005, D5, 0, 1'b0, 0, e);
    req(0, 1'b0, 10'h005, '0, 0, 1'b0, 0, e);
    chk("wr_rd_05", rd[0], D5);
    req(0, 1'b0, 10'h005, '0, 5, 1'b0, 0, e);
    chk("held_cs_rd", rd[0], D5);

    req(0, 1'b1, 10'h007, D7, 0, 1'b0, 0, e);
    req(0, 1'b1, 10'h007, 128'h1234, 0, 1'b0, 4, e);
    chk("abort_rdata_rst", rd[0], 128'h0);
    req(0, 1'b0, 10'h007, '0, 0, 1'b0, 0, e);
    chk("abort_keeps_07", rd[0], D7);

    req(0, 1'b1, 10'h020, D20, 0, 1'b1, 0, e);
    req(0, 1'b0, 10'h020, '0, 0, 1'b1, 0, e);
    chk("early_drop_20", rd[0], D20);
    req(0, 1'b0, 10'h120, '0, 0, 1'b0, 0, e);
    chk("range_rd_120", rd[0], RC ? 128'h0 : D20);
    chk("range_err_120", 128'(e), 128'(RC));

    req(0, 1'b1, 10'h0FF, DA, 0, 1'b0, 0, e);
    req(0, 1'b1, 10'h1FF, DB, 1, 1'b0, 0, e);
    chk("alias_wr_err", 128'(e), 128'(RC));
    req(0, 1'b0, 10'h0FF, '0, 0, 1'b0, 0, e);
    chk("alias_rd_0ff", rd[0], RC ? DA : DB);

    req(1, 1'b1, 10'h010, E1, 0, 1'b0, 0, e);
    req(1, 1'b0, 10'h010, '0, 0, 1'b0, 0, e);
    chk("l1_b2b_010", rd[1], E1);
    req(1, 1'b1, 10'h020, E2, 0, 1'b0, 0, e);
    req(1, 1'b0, 10'h010, '0, 3, 1'b0, 0, e);
    chk("l1_held_010", rd[1], E1);
    req(1, 1'b0, 10'h120, '0, 0, 1'b0, 0, e);
    chk("l1_range_rd", rd[1], RC ? 128'h0 : E2);
    chk("l1_range_err", 128'(e), 128'(RC));
    req(1, 1'b0, 10'h020, '0, 0, 1'b1, 0, e);
    chk("l1_rd_020", rd[1], E2);

    repeat (5) begin
      @(posedge clk); #2;
    end
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
